// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
//   arb_state_e  - arbiter ownership state (IDLE, OWN0, OWN1)
//   PORT0/PORT1  - port identifiers, also the encoding of the round-robin pointer
//   cnt_width()  - burst counter width for a given MaxBurst
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Counter must be able to hold the value MaxBurst itself.
    function automatic int cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: pure-combinational winner select for ram_arbiter.
// Ports:
//   req0/req1, lock0/lock1 - requests and lock qualifiers from the two ports
//   state                  - current ownership state
//   prio                   - port that wins an unowned conflict
//   burst_expired          - locked owner has used its full burst allowance
//   gnt[1:0]               - one-hot grant (bit n = port n), all-zero when idle
//   own_path               - grant decision came from the locked-owner rule
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       lock0,
    input  logic       lock1,
    input  arb_state_e state,
    input  logic       prio,
    input  logic       burst_expired,
    output logic [1:0] gnt,
    output logic       own_path
);

    logic [1:0] free_gnt_s;

    // Arbitration when nobody holds a lock: single requester wins, conflicts go to prio.
    always_comb begin
        free_gnt_s = 2'b00;
        if (req0 && req1) begin
            free_gnt_s = (prio == PORT1) ? 2'b10 : 2'b01;
        end else begin
            free_gnt_s = {req1, req0};
        end
    end

    // Locked owner keeps the RAM unless the waiter has sat out a full burst;
    // an owner that drops req or lock falls back to free arbitration this cycle.
    always_comb begin
        gnt      = 2'b00;
        own_path = 1'b0;
        case (state)
            OWN0: begin
                if (req0 && lock0) begin
                    own_path = 1'b1;
                    gnt      = (req1 && burst_expired) ? 2'b10 : 2'b01;
                end else begin
                    gnt = free_gnt_s;
                end
            end
            OWN1: begin
                if (req1 && lock1) begin
                    own_path = 1'b1;
                    gnt      = (req0 && burst_expired) ? 2'b01 : 2'b10;
                end else begin
                    gnt = free_gnt_s;
                end
            end
            default: begin
                gnt = free_gnt_s;
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between port 0 (CPU data)
// and port 1 (DMA/loader), one access per cycle, with bounded lock bursts.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution
// in IDLE; otherwise port 0 always wins an unowned conflict.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   reqN/lockN/weN/addrN/wdataN - port N request, lock, write enable, address, data
//   gntN                        - combinational grant, access issues this cycle
//   rvalidN/rdataN              - registered read-valid, read data (= mem_data)
//   mem_addr/mem_wdata/mem_we   - RAM command; address holds last issued when idle
//   mem_data                    - RAM read data
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8,
    parameter int MaxBurst  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 lock0,
    input  logic                 lock1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AddrWidth-1:0] addr0,
    input  logic [AddrWidth-1:0] addr1,
    input  logic [DataWidth-1:0] wdata0,
    input  logic [DataWidth-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DataWidth-1:0] rdata0,
    output logic [DataWidth-1:0] rdata1,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [DataWidth-1:0] mem_data
);

    localparam int                CntWidth = cnt_width(MaxBurst);
    localparam logic [CntWidth-1:0] CNT_MAX  = CntWidth'(MaxBurst);
    localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);

    arb_state_e           state_r;
    logic [CntWidth-1:0]  burst_cnt_r;
    logic [AddrWidth-1:0] last_addr_r;
    logic                 rvalid0_r;
    logic                 rvalid1_r;
    logic                 prio_s;
    logic [1:0]           gnt_s;
    logic                 own_path_s;
    logic                 burst_expired_s;
    logic                 owner_granted_s;
    logic                 win_lock_s;
    arb_state_e           win_state_s;

    assign burst_expired_s = (burst_cnt_r == CNT_MAX);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic prio_r;

    // Round-robin pointer: after every free (non-owner) grant, favour the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= PORT0;
        end else if ((gnt_s != 2'b00) && !own_path_s) begin
            prio_r <= gnt_s[0] ? PORT1 : PORT0;
        end else begin
            prio_r <= prio_r;
        end
    end

    assign prio_s = prio_r;
`else
    assign prio_s = PORT0;
`endif

    ram_arb_pick u_pick (
        .req0          (req0),
        .req1          (req1),
        .lock0         (lock0),
        .lock1         (lock1),
        .state         (state_r),
        .prio          (prio_s),
        .burst_expired (burst_expired_s),
        .gnt           (gnt_s),
        .own_path      (own_path_s)
    );

    assign gnt0    = gnt_s[0];
    assign gnt1    = gnt_s[1];
    assign rvalid0 = rvalid0_r;
    assign rvalid1 = rvalid1_r;
    assign rdata0  = mem_data;
    assign rdata1  = mem_data;

    // Granted port drives the RAM; when idle the address is parked so RAM data stays put.
    always_comb begin
        mem_addr  = last_addr_r;
        mem_wdata = {DataWidth{1'b0}};
        mem_we    = 1'b0;
        if (gnt_s[1]) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1;
        end else if (gnt_s[0]) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0;
        end else begin
            mem_addr  = last_addr_r;
            mem_wdata = {DataWidth{1'b0}};
            mem_we    = 1'b0;
        end
    end

    // Classify the grant: owner continuing its burst vs. a fresh winner (possibly locking).
    always_comb begin
        owner_granted_s = own_path_s &&
                          (((state_r == OWN0) && gnt_s[0]) || ((state_r == OWN1) && gnt_s[1]));
        if (gnt_s[1]) begin
            win_lock_s  = lock1;
            win_state_s = OWN1;
        end else begin
            win_lock_s  = lock0;
            win_state_s = OWN0;
        end
    end

    // Ownership FSM, burst counter, parked address and read-valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            burst_cnt_r <= {CntWidth{1'b0}};
            last_addr_r <= {AddrWidth{1'b0}};
            rvalid0_r   <= 1'b0;
            rvalid1_r   <= 1'b0;
        end else begin
            last_addr_r <= mem_addr;
            rvalid0_r   <= gnt_s[0] & ~we0;
            rvalid1_r   <= gnt_s[1] & ~we1;
            if (owner_granted_s) begin
                // Saturate so a waiter arriving late is served on its first cycle.
                state_r     <= state_r;
                burst_cnt_r <= burst_expired_s ? burst_cnt_r : (burst_cnt_r + CNT_ONE);
            end else if (gnt_s != 2'b00) begin
                state_r     <= win_lock_s ? win_state_s : IDLE;
                burst_cnt_r <= win_lock_s ? CNT_ONE : {CntWidth{1'b0}};
            end else begin
                state_r     <= IDLE;
                burst_cnt_r <= {CntWidth{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. A behavioural RAM sits on
// the mem_* side; a reference model of the arbitration rules and memory contents
// predicts grants, RAM commands and read data every cycle.
module tb_ram_arbiter;

    localparam int MB = 4;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, lock0, lock1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_data;

    // RAM instance: registered address, write committed at the edge
    logic [7:0] ram [0:255] = '{default: 8'h00};
    logic [7:0] ram_aq = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_aq <= mem_addr;
    end
    assign mem_data = ram[ram_aq];

    ram_arbiter #(.DataWidth(8), .AddrWidth(8), .MaxBurst(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_data(mem_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int         m_own;        // -1 none, else locked owner port
    int         m_cnt;        // grants used by owner in current burst
    int         m_prio;       // port favoured in a free conflict (round robin only)
    logic [7:0] m_last;       // last address driven to the RAM
    bit         exp_rv [2];
    logic [7:0] exp_rd [2];
    logic [7:0] ref_mem [0:255] = '{default: 8'h00};
    int         m_win;        // winner of the most recent cycle, -1 none

    // Stimulus staging
    logic       s_req [2];
    logic       s_lock [2];
    logic       s_we [2];
    logic [7:0] s_addr [2];
    logic [7:0] s_wdata [2];

    task automatic model_reset();
        m_own = -1; m_cnt = 0; m_prio = 0; m_last = 8'h00;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        m_win = -1;
    endtask

    task automatic clear_stim();
        for (int p = 0; p < 2; p++) begin
            s_req[p] = 1'b0; s_lock[p] = 1'b0; s_we[p] = 1'b0;
            s_addr[p] = 8'h00; s_wdata[p] = 8'h00;
        end
    endtask

    // One clock: check registered outputs, drive staged inputs, predict and check grant.
    task automatic cycle();
        int         win;
        int         oth;
        logic [7:0] eaddr;
        logic       ewe;
        logic [1:0] eg;
        @(negedge clk);
        tb_check("rvalid0", rvalid0, exp_rv[0]);
        tb_check("rvalid1", rvalid1, exp_rv[1]);
        if (exp_rv[0]) tb_check("rdata0", rdata0, exp_rd[0]);
        if (exp_rv[1]) tb_check("rdata1", rdata1, exp_rd[1]);
        req0 = s_req[0]; lock0 = s_lock[0]; we0 = s_we[0]; addr0 = s_addr[0]; wdata0 = s_wdata[0];
        req1 = s_req[1]; lock1 = s_lock[1]; we1 = s_we[1]; addr1 = s_addr[1]; wdata1 = s_wdata[1];
        #1;
        win = -1;
        if (m_own >= 0 && s_req[m_own] && s_lock[m_own]) begin
            oth = 1 - m_own;
            if (s_req[oth] && m_cnt == MB) begin
                win = oth;
                m_own = s_lock[oth] ? oth : -1;
                m_cnt = s_lock[oth] ? 1 : 0;
            end else begin
                win = m_own;
                if (m_cnt < MB) m_cnt = m_cnt + 1;
            end
        end else begin
            if (s_req[0] && s_req[1]) win = RR ? m_prio : 0;
            else if (s_req[0]) win = 0;
            else if (s_req[1]) win = 1;
            if (win >= 0) begin
                if (RR) m_prio = 1 - win;
                m_own = s_lock[win] ? win : -1;
                m_cnt = s_lock[win] ? 1 : 0;
            end else begin
                m_own = -1;
                m_cnt = 0;
            end
        end
        eg    = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
        eaddr = (win >= 0) ? s_addr[win] : m_last;
        ewe   = (win >= 0) ? s_we[win] : 1'b0;
        tb_check("gnt", {gnt1, gnt0}, eg);
        tb_check("mem_addr", mem_addr, eaddr);
        tb_check("mem_we", mem_we, ewe);
        if (ewe) tb_check("mem_wdata", mem_wdata, s_wdata[win]);
        m_last = eaddr;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        if (win >= 0) begin
            if (s_we[win]) ref_mem[eaddr] = s_wdata[win];
            else begin
                exp_rv[win] = 1'b1;
                exp_rd[win] = ref_mem[eaddr];
            end
        end
        m_win = win;
    endtask

    int         pend [2];
    int         gap [2];
    int         waitc [2];
    logic [11:0] burst_pat;

    initial begin
        rst_n = 1'b0;
        clear_stim();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        tb_check("rst_gnt", {gnt1, gnt0}, 2'b00);
        tb_check("rst_mem_we", mem_we, 1'b0);
        tb_check("rst_mem_addr", mem_addr, 8'h00);
        tb_check("rst_mem_wdata", mem_wdata, 8'h00);
        tb_check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        rst_n = 1'b1;

        // Reset asserted while a read's data is being returned
        s_req[0] = 1'b1; s_addr[0] = 8'h33;
        cycle();
        @(posedge clk); #1;
        tb_check("pre_reset_rvalid0", rvalid0, 1'b1);
        req0 = 1'b0; clear_stim();
        rst_n = 1'b0;
        #1;
        tb_check("async_rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        tb_check("async_rst_mem_we", mem_we, 1'b0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        cycle();
        tb_check("post_reset_mem_addr", mem_addr, 8'h00);

        // Conflict in IDLE; port 0 drops after its grant
        s_req[0] = 1'b1; s_req[1] = 1'b1; s_addr[0] = 8'h01; s_addr[1] = 8'h02;
        cycle();
        tb_check("conflict_first", {gnt1, gnt0}, 2'b01);
        s_req[0] = 1'b0;
        cycle();
        tb_check("conflict_second", {gnt1, gnt0}, 2'b10);

        // Four cycles of continuous conflict
        s_req[0] = 1'b1; s_req[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            tb_check("conflict_seq", {gnt1, gnt0},
                     (RR && (i % 2 == 1)) ? 2'b10 : 2'b01);
        end
        clear_stim();
        cycle();

        // Port 0 write 0x5A @0x10, then read back
        s_req[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 8'h10; s_wdata[0] = 8'h5A;
        cycle();
        tb_check("wr_gnt0", gnt0, 1'b1);
        s_we[0] = 1'b0;
        cycle();
        tb_check("rd_gnt0", gnt0, 1'b1);
        s_req[0] = 1'b0;
        cycle();
        tb_check("rd_rvalid0", rvalid0, 1'b1);
        tb_check("rd_rdata0", rdata0, 8'h5A);

        // Idle after a read @0x22: address parked, data stable
        s_req[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 8'h22; s_wdata[0] = 8'hC3;
        cycle();
        clear_stim();
        s_req[1] = 1'b1; s_addr[1] = 8'h22;
        cycle();
        clear_stim();
        for (int i = 0; i < 3; i++) begin
            cycle();
            tb_check("idle_mem_addr", mem_addr, 8'h22);
            tb_check("idle_mem_we", mem_we, 1'b0);
            tb_check("idle_rdata1", rdata1, 8'hC3);
        end

        // Port 1 locked burst of reads with port 0 re-requesting after each grant
        burst_pat = 12'hDEF;
        for (int c = 0; c < 12; c++) begin
            s_req[1] = 1'b1; s_lock[1] = 1'b1; s_addr[1] = 8'(8'h40 + c);
            s_req[0] = (c != 0) && (m_win != 0); s_addr[0] = 8'h50;
            cycle();
            tb_check("burst_gnt", {gnt1, gnt0}, burst_pat[c] ? 2'b10 : 2'b01);
        end
        s_req[1] = 1'b0; s_lock[1] = 1'b0;
        cycle();
        tb_check("burst_release_gnt0", {gnt1, gnt0}, 2'b01);
        clear_stim();
        cycle();

        // Random two-port traffic against the reference model
        for (int p = 0; p < 2; p++) begin pend[p] = 0; gap[p] = 0; waitc[p] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (gap[p] > 0) gap[p]--;
                else if (pend[p] == 0 && $urandom_range(0, 9) < 6) begin
                    pend[p]    = 1;
                    waitc[p]   = 0;
                    s_lock[p]  = ($urandom_range(0, 2) == 0);
                    s_we[p]    = $urandom_range(0, 1);
                    s_addr[p]  = 8'($urandom_range(0, 15));
                    s_wdata[p] = 8'($urandom);
                end
                s_req[p] = (pend[p] != 0);
            end
            cycle();
            for (int p = 0; p < 2; p++) begin
                if (pend[p] != 0) begin
                    waitc[p]++;
                    if (m_win == p) begin
                        tb_check("grant_latency", (waitc[p] <= 2 * MB + 1), 1'b1);
                        pend[p] = 0;
                        gap[p]  = s_lock[p] ? 0 : 1;
                    end
                end
            end
        end
        clear_stim();
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
